// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer blocks
// (write side wptr_full, read side rptr_empty).
//
// Contents:
//   ADDRSIZE_DFLT, DEPTH, PTRW   default geometry (depth 16, 5-bit pointers)
//   GW                           widest pointer the helper functions handle
//   bin2gray / gray2bin          binary <-> reflected Gray conversion
//
// The helpers work on GW-bit vectors. A narrower pointer is zero-extended on
// the way in and truncated on the way out. Zero bits above the pointer do not
// change either conversion, so one pair of functions serves every pointer
// width up to GW.
package fifo_pkg;

  localparam int ADDRSIZE_DFLT = 4;
  localparam int DEPTH         = 2 ** ADDRSIZE_DFLT;
  localparam int PTRW          = ADDRSIZE_DFLT + 1;

  localparam int GW = 32;

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of every Gray bit at or above it.
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b = g;
    for (int i = 1; i < GW; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full.sv
// wptr_full
// Write-domain pointer and full/level generator for the asynchronous FIFO.
//
// Ports:
//   w_clk          write-domain clock
//   w_rst          asynchronous, active-high reset
//   w_inc          write request; ignored while w_full is set
//   s_wr_ptr       Gray read pointer, already synchronized into w_clk
//   waddr          RAM write address (low bits of the binary write pointer)
//   wptr           registered Gray write pointer, sent to the w2r synchronizer
//   w_full         registered full flag
//   w_almost_full  registered, set when free slots <= AF_MARGIN
//   w_level        registered occupancy as seen from the write side
//   w_overflow     sticky "write attempted while full"
//
// Build option: define WPTR_OVERFLOW_STICKY_EN to build the sticky overflow
// register. Without it, w_overflow is tied low and no register is built.
// The port list is the same in both builds.
//
// The read pointer arrives two w_clk cycles late. As a result, full and level
// can only over-report occupancy. They never show fewer entries than are
// actually stored.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = ADDRSIZE_DFLT,
  parameter int AF_MARGIN = 2
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_inc,
  input  logic [ADDRSIZE:0] s_wr_ptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0] wptr,
  output logic              w_full,
  output logic              w_almost_full,
  output logic [ADDRSIZE:0] w_level,
  output logic              w_overflow
);

  localparam int PTR_W      = ADDRSIZE + 1;
  localparam int FIFO_DEPTH = 2 ** ADDRSIZE;
  localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(FIFO_DEPTH - AF_MARGIN);

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] level_next;
  logic             full_next;
  logic             wr_en;

  assign wr_en      = w_inc & ~w_full;
  assign waddr      = wbin[ADDRSIZE-1:0];
  assign wbin_next  = wbin + {{ADDRSIZE{1'b0}}, wr_en};
  assign wgray_next = PTR_W'(bin2gray(GW'(wbin_next)));
  assign rbin_s     = PTR_W'(gray2bin(GW'(s_wr_ptr)));
  assign level_next = wbin_next - rbin_s;

  // The write pointer is one full lap ahead of the read pointer when it
  // matches the read pointer with its two top Gray bits inverted.
  assign full_next = (wgray_next ==
                      {~s_wr_ptr[ADDRSIZE:ADDRSIZE-1], s_wr_ptr[ADDRSIZE-2:0]});

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      wbin          <= '0;
      wptr          <= '0;
      w_full        <= 1'b0;
      w_almost_full <= 1'b0;
      w_level       <= '0;
    end else begin
      wbin          <= wbin_next;
      wptr          <= wgray_next;
      w_full        <= full_next;
      w_almost_full <= (level_next >= AF_THRESH);
      w_level       <= level_next;
    end
  end

`ifdef WPTR_OVERFLOW_STICKY_EN
  logic overflow_q;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      overflow_q <= 1'b0;
    end else if (w_inc && w_full) begin
      overflow_q <= 1'b1;
    end
  end

  assign w_overflow = overflow_q;
`else
  assign w_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
module tb_wptr_full;

  localparam int A = 4;

  typedef struct {
    string      tag;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       af;
    logic [4:0] level;
    logic       ovf;
  } exp_t;

  logic       w_clk = 1'b0;
  logic       w_rst = 1'b1;
  logic       w_inc = 1'b0;
  logic [4:0] s_wr_ptr = '0;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       w_full;
  logic       w_almost_full;
  logic [4:0] w_level;
  logic       w_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t sb[$];

  // Independent model: binary write count and binary read count.
  int   m_wbin = 0;
  int   m_rbin = 0;
  logic m_full = 1'b0;
  logic m_ovf  = 1'b0;

  wptr_full #(.ADDRSIZE(A), .AF_MARGIN(2)) dut (
    .w_clk(w_clk),
    .w_rst(w_rst),
    .w_inc(w_inc),
    .s_wr_ptr(s_wr_ptr),
    .waddr(waddr),
    .wptr(wptr),
    .w_full(w_full),
    .w_almost_full(w_almost_full),
    .w_level(w_level),
    .w_overflow(w_overflow)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_wbin = 0;
    m_rbin = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle, push the expected post-edge state, then pop and compare.
  task automatic step(input logic inc, input int rcnt, input string tag);
    exp_t e;
    int   lvl;
    bit   accept;
    m_rbin   = rcnt & 31;
    w_inc    = inc;
    s_wr_ptr = gray5(m_rbin);
    accept   = inc && !m_full;
`ifdef WPTR_OVERFLOW_STICKY_EN
    if (inc && m_full) m_ovf = 1'b1;
`endif
    m_wbin  = (m_wbin + (accept ? 1 : 0)) & 31;
    lvl     = (m_wbin - m_rbin) & 31;
    m_full  = (lvl == 16);
    e.tag   = tag;
    e.waddr = 4'(m_wbin);
    e.wptr  = gray5(m_wbin);
    e.full  = m_full;
    e.af    = (lvl >= 14);
    e.level = 5'(lvl);
    e.ovf   = m_ovf;
    sb.push_back(e);
    @(posedge w_clk);
    #1;
    e = sb.pop_front();
    cmp({e.tag, ".waddr"}, 32'(waddr), 32'(e.waddr));
    cmp({e.tag, ".wptr"}, 32'(wptr), 32'(e.wptr));
    cmp({e.tag, ".full"}, 32'(w_full), 32'(e.full));
    cmp({e.tag, ".af"}, 32'(w_almost_full), 32'(e.af));
    cmp({e.tag, ".level"}, 32'(w_level), 32'(e.level));
    cmp({e.tag, ".ovf"}, 32'(w_overflow), 32'(e.ovf));
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".waddr"}, 32'(waddr), 0);
    cmp({tag, ".wptr"}, 32'(wptr), 0);
    cmp({tag, ".full"}, 32'(w_full), 0);
    cmp({tag, ".af"}, 32'(w_almost_full), 0);
    cmp({tag, ".level"}, 32'(w_level), 0);
    cmp({tag, ".ovf"}, 32'(w_overflow), 0);
  endtask

  // Pulse reset away from the clock edge and check outputs before the next edge.
  task automatic async_reset(input string tag);
    @(posedge w_clk);
    #2 w_rst = 1'b1;
    w_inc = 1'b0;
    s_wr_ptr = '0;
    #1;
    check_zero(tag);
    #1 w_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [4:0] prev_wptr;
    logic [3:0] prev_waddr;
    int         wraps;

    // Power-on reset
    #12;
    check_zero("por");
    w_rst = 1'b0;
    model_reset();

    // Reset in the middle of a write burst
    for (int i = 0; i < 5; i++) step(1'b1, 0, "burst");
    async_reset("midrst");
    cmp("midrst.next_waddr", 32'(waddr), 0);
    step(1'b1, 0, "after_rst");
    cmp("after_rst.level", 32'(w_level), 1);
    async_reset("rst2");

    // Fill to 13 / 14 / 16 entries
    for (int i = 0; i < 13; i++) step(1'b1, 0, "fill");
    cmp("af13", 32'(w_almost_full), 0);
    step(1'b1, 0, "fill14");
    cmp("af14", 32'(w_almost_full), 1);
    cmp("lvl14", 32'(w_level), 14);
    step(1'b1, 0, "fill15");
    step(1'b1, 0, "fill16");
    cmp("full16", 32'(w_full), 1);
    cmp("wptr16", 32'(wptr), 32'h18);
    cmp("lvl16", 32'(w_level), 16);

    // A write while full is dropped
    step(1'b1, 0, "drop17");
    cmp("drop17.waddr", 32'(waddr), 0);
    cmp("drop17.wptr", 32'(wptr), 32'h18);

    // Read pointer advances by one: full releases on the next edge
    step(1'b0, 1, "drain");
    cmp("drain.full", 32'(w_full), 0);
    cmp("drain.level", 32'(w_level), 15);
    step(1'b1, 1, "refill");
    cmp("refill.full", 32'(w_full), 1);

    // Overflow stays set through a further read
    step(1'b1, 1, "ovf_hit");
    step(1'b0, 2, "ovf_hold");
`ifdef WPTR_OVERFLOW_STICKY_EN
    cmp("ovf_sticky", 32'(w_overflow), 1);
`else
    cmp("ovf_tied", 32'(w_overflow), 0);
`endif
    async_reset("ovf_clr");

    // Wrap-around with the read pointer trailing three entries behind
    for (int i = 0; i < 3; i++) step(1'b1, 0, "prime");
    wraps = 0;
    for (int i = 0; i < 40; i++) begin
      prev_wptr  = wptr;
      prev_waddr = waddr;
      step(1'b1, m_wbin + 1 - 3, "wrap");
      cmp("wrap.hamming", 32'($countones(prev_wptr ^ wptr)), 1);
      if (prev_waddr == 4'd15 && waddr == 4'd0) wraps++;
    end
    cmp("wrap.count", 32'(wraps), 2);
    cmp("wrap.level", 32'(w_level), 3);

    cmp("sb.empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
- Write-domain pointer and full-flag generator for the asynchronous FIFO.
- Consumes the two-flop synchronized Gray read pointer (`s_wr_ptr`) produced by the read-to-write synchronizer.
- Produces three things:
  - the binary write address for the dual-port RAM;
  - the Gray write pointer sent to the write-to-read synchronizer;
  - registered full, almost-full and fill-level status.

Parameters:
- ADDRSIZE, 4, address width; FIFO depth = 2**ADDRSIZE; legal range ≥ 2.
- AF_MARGIN, 2, almost-full asserts when free slots ≤ AF_MARGIN; legal range 1..2**ADDRSIZE-1.

Ports:
- w_clk  input  1  write-domain clock.
- w_rst  input  1  reset, asynchronous and active-high.
- w_inc  input  1  write request.
- s_wr_ptr  input  ADDRSIZE+1  synchronized Gray read pointer, already in the w_clk domain.
- waddr  output  ADDRSIZE  RAM write address.
- wptr  output  ADDRSIZE+1  Gray write pointer, registered, to the w2r synchronizer.
- w_full  output  1  FIFO full, registered.
- w_almost_full  output  1  free slots ≤ AF_MARGIN, registered.
- w_level  output  ADDRSIZE+1  occupancy seen from the write side, 0..2**ADDRSIZE, registered.
- w_overflow  output  1  sticky overflow; see Optional Feature.

Behaviour:
- One clock: w_clk. Reset is asynchronous and active-high (w_rst).
- Reset (assert anytime, including mid-burst): all registers clear immediately: wbin=0, wptr=0, w_full=0, w_almost_full=0, w_level=0, w_overflow=0.
- Write acceptance:
  - wr_en = w_inc & ~w_full. Writes while full are dropped; no pointer movement.
  - waddr = wbin[ADDRSIZE-1:0] of the current cycle; the RAM writes this slot on the same edge.
- Pointer arithmetic:
  - wbin_next = wbin + wr_en, modulo 2**(ADDRSIZE+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - wbin and wptr load their next values each edge. wptr changes by at most one bit per cycle.
- Full:
  - w_full <= (wgray_next == {~s_wr_ptr[ADDRSIZE:ADDRSIZE-1], s_wr_ptr[ADDRSIZE-2:0]}).
  - w_full rises on the same edge that accepts the write filling the last slot.
- Level:
  - rbin_s = gray-to-binary(s_wr_ptr), combinational.
  - w_level <= wbin_next - rbin_s, modulo 2**(ADDRSIZE+1).
  - w_almost_full <= (w_level_next ≥ 2**ADDRSIZE - AF_MARGIN).
- Pessimism: the read pointer is seen 2 w_clk late, so full and level over-report occupancy. Required behaviour:
  - w_full deasserts on the first edge after s_wr_ptr advances.
  - The block never reports fewer entries than actually present.
- Wrap-around: the binary wrap from 2**(ADDRSIZE+1)-1 to 0 is normal operation. The extra MSB distinguishes full from empty.
- Simultaneous events: a write and a read-pointer advance in the same cycle leave w_level unchanged and w_full unchanged (if not full).
- No state machine; the block is a pure registered datapath.

Optional Feature:
- Macro: WPTR_OVERFLOW_STICKY_EN.
- Defined: w_overflow <= 1 on any edge with w_inc & w_full; it holds until w_rst.
- Undefined: w_overflow is tied to 0 and no register is built. The port list is identical in both builds.

Decomposition:
- Shared package fifo_pkg holds:
  - localparams DEPTH = 2**ADDRSIZE and PTRW = ADDRSIZE+1;
  - functions bin2gray and gray2bin, parameterized by width. These are reused by the read-side rptr_empty block.
- No sub-module: the block is a single module. gray2bin is a package function, not an instance.

Test Plan (ADDRSIZE=4, AF_MARGIN=2, s_wr_ptr held at 0 unless stated):
- Reset: pulse w_rst mid-write burst → all outputs read 0 asynchronously, before the next w_clk edge; the next accepted write uses waddr=0.
- Fill: 16 consecutive w_inc → waddr steps 0..15; w_full=1 after the 16th edge; wptr=5'b11000; w_level=16. A 17th w_inc is ignored: waddr stays 0, wptr unchanged.
- Almost-full: 14 writes → w_almost_full=1 and w_level=14 after the 14th edge; w_almost_full=0 after 13 writes.
- Drain release: from full, set s_wr_ptr=5'b00001 (Gray of 1) → w_full=0 and w_level=15 on the next edge; one further write re-asserts w_full.
- Wrap and Gray check: 40 writes with s_wr_ptr tracking gray(wbin-3) → waddr wraps 15→0 twice; wptr has Hamming distance 1 per accepted write; w_level=3 steady; w_full never asserts.
- Overflow (macro defined): w_inc while full → w_overflow=1 next edge, sticky through subsequent reads, cleared only by w_rst. Macro undefined → w_overflow stays 0.
